avalon_mm_pwm_capture: RTL

Four-channel PWM input-capture peripheral on an Avalon-MM slave port, the measuring counterpart to the team's PWM generator. Each channel measures the period and high time of an external PWM signal in prescaled clock ticks and exposes the results as 16-bit read-only registers. It sits beside the PWM generator in the Qsys system, typically looping back its outputs or reading servo/fan feedback.

---
 rtl/pwm_cap_pkg.sv | 23 ++
 rtl/pwm_capture_channel.sv | 97 +++++++++
 rtl/avalon_mm_pwm_capture.sv | 94 +++++++++
 3 files changed

// File: rtl/pwm_cap_pkg.sv
`default_nettype none
// pwm_cap_pkg -- address map, widths and channel state type for avalon_mm_pwm_capture (rev 1.0)

package pwm_cap_pkg;

  localparam int CNT_W = 16;
  localparam int NCH   = 4;

  localparam logic [3:0] ADDR_PERIOD0 = 4'h0;
  localparam logic [3:0] ADDR_HIGH0   = 4'h4;
  localparam logic [3:0] ADDR_DIV     = 4'h8;
  localparam logic [3:0] ADDR_STATUS  = 4'h9;
  localparam logic [3:0] ADDR_CTRL    = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } ch_state_t;

endpackage

`default_nettype wire

// File: rtl/pwm_capture_channel.sv
`default_nettype none
// pwm_capture_channel -- one PWM capture channel: synchronizer, IDLE/ARM/MEASURE FSM, counters (rev 1.0)
// Optional PWM_CAP_TIMEOUT_EN reports a static level when the period counter saturates.

module pwm_capture_channel
  import pwm_cap_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             enable,
  input  logic             pin,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high,
  output logic             valid_set,
  output logic             ovf_set
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_NEAR = CNT_MAX - 1'b1;

  logic             s1, s2, s3;
  ch_state_t        state;
  logic [CNT_W-1:0] cnt_p, cnt_h;
  logic [CNT_W-1:0] load_val;
  logic             rise, latch, sat_now;

  assign rise     = s2 & ~s3;
  assign load_val = {{(CNT_W-1){1'b0}}, tick};
  assign latch    = (state == ST_MEASURE) && enable && rise;
  assign sat_now  = (state == ST_MEASURE) && enable && !rise && tick && (cnt_p == CNT_NEAR);
  assign ovf_set  = sat_now;
`ifdef PWM_CAP_TIMEOUT_EN
  assign valid_set = latch | sat_now;
`else
  assign valid_set = latch;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      state  <= ST_ARM;
      cnt_p  <= '0;
      cnt_h  <= '0;
      period <= '0;
      high   <= '0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      s3 <= s2;
      case (state)
        ST_IDLE: begin
          cnt_p <= '0;
          cnt_h <= '0;
          if (enable) state <= ST_ARM;
        end
        ST_ARM: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else if (rise) begin
            cnt_p <= load_val;
            cnt_h <= load_val;
            state <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (!enable) begin
            state <= ST_IDLE;
            cnt_p <= '0;
            cnt_h <= '0;
          end else if (rise) begin
            period <= cnt_p;
            high   <= cnt_h;
            cnt_p  <= load_val;
            cnt_h  <= load_val;
          end else begin
            if (tick && cnt_p != CNT_MAX) cnt_p <= cnt_p + 1'b1;
            // s2 is the level one stage ahead of s3, so the edge cycle already loaded as 1 is not counted twice
            if (tick && s2 && cnt_h != CNT_MAX) cnt_h <= cnt_h + 1'b1;
`ifdef PWM_CAP_TIMEOUT_EN
            if (sat_now) begin
              period <= CNT_MAX;
              high   <= s3 ? CNT_MAX : '0;
            end
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/avalon_mm_pwm_capture.sv
`default_nettype none
// avalon_mm_pwm_capture -- 4-channel PWM input capture on an Avalon-MM slave (rev 1.0)
// Build option: PWM_CAP_TIMEOUT_EN forces period/high to a static-level report on counter saturation.

module avalon_mm_pwm_capture
  import pwm_cap_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       address,
  input  logic             read,
  output logic [CNT_W-1:0] readdata,
  input  logic             write,
  input  logic [CNT_W-1:0] writedata,
  input  logic             capture1,
  input  logic             capture2,
  input  logic             capture3,
  input  logic             capture4
);

  logic [7:0]       div, pre_cnt;
  logic             tick;
  logic [NCH-1:0]   enable, valid, ovf, valid_set, ovf_set, pins;
  logic [CNT_W-1:0] period [NCH];
  logic [CNT_W-1:0] high   [NCH];
  logic [CNT_W-1:0] rd_mux;
  logic             wr_div, wr_status, wr_ctrl;
  logic             unused_wdata;

  assign pins         = {capture4, capture3, capture2, capture1};
  assign tick         = (pre_cnt == div);
  assign wr_div       = write && (address == ADDR_DIV);
  assign wr_status    = write && (address == ADDR_STATUS);
  assign wr_ctrl      = write && (address == ADDR_CTRL);
  assign unused_wdata = ^writedata[CNT_W-1:8];

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      pwm_capture_channel u_ch (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .enable    (enable[i]),
        .pin       (pins[i]),
        .period    (period[i]),
        .high      (high[i]),
        .valid_set (valid_set[i]),
        .ovf_set   (ovf_set[i])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_cnt <= '0;
      div     <= '0;
      enable  <= '1;
      valid   <= '0;
      ovf     <= '0;
    end else begin
      if (wr_div || tick) pre_cnt <= '0;
      else                pre_cnt <= pre_cnt + 1'b1;
      if (wr_div)  div    <= writedata[7:0];
      if (wr_ctrl) enable <= writedata[NCH-1:0];
      // hardware set is OR-ed after the W1C clear so a same-cycle event is never lost
      valid <= (valid & ~(wr_status ? writedata[3:0] : 4'h0)) | valid_set;
      ovf   <= (ovf   & ~(wr_status ? writedata[7:4] : 4'h0)) | ovf_set;
    end
  end

  always_comb begin
    rd_mux = '0;
    if ((address & 4'hC) == ADDR_PERIOD0) begin
      rd_mux = period[address[1:0]];
    end else if ((address & 4'hC) == ADDR_HIGH0) begin
      rd_mux = high[address[1:0]];
    end else begin
      case (address)
        ADDR_DIV:    rd_mux = CNT_W'(div);
        ADDR_STATUS: rd_mux = CNT_W'({ovf, valid});
        ADDR_CTRL:   rd_mux = CNT_W'(enable);
        default:     rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)    readdata <= '0;
    else if (read) readdata <= rd_mux;
  end

endmodule

`default_nettype wire
